decrypt_unit: RTL and testbench

//   Inverse of the 8-bit nibble-Feistel ENCRYPT datapath. Accepts one

---
 rtl/decrypt_unit_pkg.sv | 25 ++
 rtl/decrypt_unit_feistel_round_f.sv | 12 +
 rtl/decrypt_unit.sv | 94 +++++++++
 tb/tb_decrypt_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/decrypt_unit_pkg.sv
// Shared definitions for the nibble-Feistel cipher: expansion permutation,
// round function and the FSM state encoding. The encrypt and decrypt sides
// both import this so the round function cannot diverge between them.
package decrypt_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // Expansion permutation: spreads the 4-bit half-block over 8 bits.
    function automatic logic [7:0] expand(input logic [3:0] lo);
        return {lo[3], lo[0], lo[1], lo[2], lo[1], lo[3], lo[2], lo[0]};
    endfunction

    // Round function. The carry-in is the inverted key[0], which matches the
    // carry-select adder on the encrypt side; the carry-out is dropped.
    function automatic logic [3:0] round_f(input logic [3:0] lo, input logic [7:0] k);
        logic [7:0] x;
        x = expand(lo) ^ k;
        return x[7:4] + x[3:0] + {3'b000, ~k[0]};
    endfunction

endpackage

// File: rtl/decrypt_unit_feistel_round_f.sv
// Combinational Feistel round function f(lo, k) -> 4-bit mask.
module feistel_round_f
    import decrypt_unit_pkg::*;
(
    input  logic [3:0] lo,
    input  logic [7:0] k,
    output logic [3:0] f
);

    assign f = round_f(lo, k);

endmodule

// File: rtl/decrypt_unit.sv
// Single-block-in-flight decryptor for the 8-bit nibble-Feistel cipher.
// Captures {enc_number, key} on the input handshake, computes the plaintext
// in one cycle, and holds it on the output handshake until accepted.
module decrypt_unit
    import decrypt_unit_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [7:0]       enc_number,
    input  logic [7:0]       key,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       dec_number,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] blk_count
);

    state_t           state;
    state_t           state_next;
    logic [7:0]       enc_q;
    logic [7:0]       key_q;
    logic [7:0]       dec_q;
    logic [3:0]       f_val;

    // Round function sees only the captured registers, never the live inputs.
    feistel_round_f u_round_f (
        .lo (enc_q[3:0]),
        .k  (key_q),
        .f  (f_val)
    );

    // State register with synchronous reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next-state and handshake outputs, all decoded from the current state.
    always_comb begin
        // NOTE: defaults first so no path through this block infers a latch.
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        unique case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_next = ST_CALC;
            end
            ST_CALC: begin
                state_next = ST_OUT;
            end
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Capture registers, result register and delivered-block counter.
    always_ff @(posedge clock) begin
        // NOTE: every datapath register is reset so an aborted block leaves no
        // stale data on dec_number or in the capture registers.
        if (reset) begin
            enc_q     <= 8'h00;
            key_q     <= 8'h00;
            dec_q     <= 8'h00;
            blk_count <= '0;
        end else begin
            if (state == ST_IDLE && in_valid) begin
                enc_q <= enc_number;
                key_q <= key;
            end
            if (state == ST_CALC) begin
                dec_q <= {enc_q[7:4] ^ f_val, enc_q[3:0]};
            end
            if (state == ST_OUT && out_ready) begin
                blk_count <= blk_count + CNT_W'(1);
            end
        end
    end

    assign dec_number = dec_q;

endmodule

// File: tb/tb_decrypt_unit.sv
// Directed bench for decrypt_unit: hand-computed vectors, a sampled
// encrypt/decrypt loop-back against an independent encrypt model, output
// stall, mid-block reset, and counter wrap on a CNT_W=2 instance.
module tb_decrypt_unit;

    logic       clock;
    logic       reset;
    logic [7:0] enc_number;
    logic [7:0] key;
    logic       in_valid;
    logic       out_ready;

    logic       in_ready;
    logic [7:0] dec_number;
    logic       out_valid;
    logic       busy;
    logic [7:0] blk_count;

    logic       s_in_ready;
    logic [7:0] s_dec_number;
    logic       s_out_valid;
    logic       s_busy;
    logic [1:0] s_blk_count;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_cnt  = 0;

    decrypt_unit #(.CNT_W(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .enc_number (enc_number),
        .key        (key),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dec_number (dec_number),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .blk_count  (blk_count)
    );

    // Narrow-counter instance shares the stimulus; only its counter is checked.
    decrypt_unit #(.CNT_W(2)) dut_small (
        .clock      (clock),
        .reset      (reset),
        .enc_number (enc_number),
        .key        (key),
        .in_valid   (in_valid),
        .in_ready   (s_in_ready),
        .dec_number (s_dec_number),
        .out_valid  (s_out_valid),
        .out_ready  (out_ready),
        .busy       (s_busy),
        .blk_count  (s_blk_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Independent encrypt model: each expanded bit written out explicitly.
    function automatic logic [7:0] enc_model(input logic [7:0] num, input logic [7:0] k);
        logic [7:0] e;
        logic [7:0] x;
        int         s;
        e[7] = num[3]; e[6] = num[0]; e[5] = num[1]; e[4] = num[2];
        e[3] = num[1]; e[2] = num[3]; e[1] = num[2]; e[0] = num[0];
        x = e ^ k;
        s = int'(x[7:4]) + int'(x[3:0]) + (k[0] ? 0 : 1);
        return {num[7:4] ^ 4'(s % 16), num[3:0]};
    endfunction

    // One block with out_ready already high: accepted in its first OUT cycle.
    task automatic do_block(input string tag, input logic [7:0] enc,
                            input logic [7:0] k, input logic [7:0] exp_dec);
        enc_number = enc;
        key        = k;
        in_valid   = 1'b1;
        out_ready  = 1'b1;
        tick();
        in_valid   = 1'b0;
        enc_number = ~enc;
        key        = ~k;
        check({tag, "_calc_in_ready"}, in_ready, 1'b0);
        check({tag, "_calc_out_valid"}, out_valid, 1'b0);
        tick();
        check({tag, "_out_valid"}, out_valid, 1'b1);
        check({tag, "_dec"}, dec_number, exp_dec);
        tick();
        exp_cnt = (exp_cnt + 1) % 256;
        check({tag, "_count"}, blk_count, exp_cnt);
        check({tag, "_idle"}, in_ready, 1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        exp_cnt = 0;
    endtask

    initial begin
        logic [7:0] num;
        logic [7:0] k;
        logic [7:0] held;
        int         seq [5] = '{1, 2, 3, 0, 1};

        reset      = 1'b1;
        enc_number = 8'h00;
        key        = 8'h00;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_dec", dec_number, 8'h00);
        check("rst_count", blk_count, 8'h00);

        // Hand-computed vectors: k0=1 case and the f=0 identity case.
        do_block("vec1", 8'b0111_0110, 8'b1001_0011, 8'b0100_0110);
        do_block("vec2", 8'b1100_1001, 8'b1010_1100, 8'b1100_1001);

        // Sampled loop-back: corner keys, then random pairs.
        do_block("lb_zero", enc_model(8'h00, 8'h00), 8'h00, 8'h00);
        do_block("lb_ones", enc_model(8'hFF, 8'hFF), 8'hFF, 8'hFF);
        for (int i = 0; i < 300; i++) begin
            num = 8'($urandom);
            k   = 8'($urandom);
            do_block("lb", enc_model(num, k), k, num);
        end

        // Output stall: held result, no new capture, then release.
        out_ready  = 1'b0;
        enc_number = 8'b0111_0110;
        key        = 8'b1001_0011;
        in_valid   = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        held = 8'b0100_0110;
        for (int i = 0; i < 5; i++) begin
            enc_number = 8'hA5;
            key        = 8'h3C;
            in_valid   = 1'b1;
            check("stall_out_valid", out_valid, 1'b1);
            check("stall_in_ready", in_ready, 1'b0);
            check("stall_dec", dec_number, held);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        exp_cnt = (exp_cnt + 1) % 256;
        check("stall_release_count", blk_count, exp_cnt);
        check("stall_release_idle", in_ready, 1'b1);
        check("stall_release_out_valid", out_valid, 1'b0);
        out_ready = 1'b0;
        tick();
        check("stall_no_capture_busy", busy, 1'b0);
        check("stall_no_capture_dec", dec_number, held);

        // Reset while in CALC.
        enc_number = 8'b0111_0110;
        key        = 8'b1001_0011;
        in_valid   = 1'b1;
        tick();
        in_valid = 1'b0;
        check("calc_busy", busy, 1'b1);
        do_reset();
        check("rcalc_in_ready", in_ready, 1'b1);
        check("rcalc_out_valid", out_valid, 1'b0);
        check("rcalc_busy", busy, 1'b0);
        check("rcalc_dec", dec_number, 8'h00);
        check("rcalc_count", blk_count, 8'h00);

        // Reset while in OUT, after the count was made nonzero.
        do_block("pre_rout", 8'b0111_0110, 8'b1001_0011, 8'b0100_0110);
        out_ready  = 1'b0;
        enc_number = 8'b0111_0110;
        key        = 8'b1001_0011;
        in_valid   = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("out_before_reset", out_valid, 1'b1);
        do_reset();
        check("rout_in_ready", in_ready, 1'b1);
        check("rout_out_valid", out_valid, 1'b0);
        check("rout_busy", busy, 1'b0);
        check("rout_dec", dec_number, 8'h00);
        check("rout_count", blk_count, 8'h00);
        tick();
        check("rout_stays_idle", busy, 1'b0);
        check("rout_count_held", blk_count, 8'h00);

        // CNT_W=2 wrap: five back-to-back blocks.
        check("small_rst_count", s_blk_count, 2'd0);
        for (int i = 0; i < 5; i++) begin
            do_block("wrap", 8'b1100_1001, 8'b1010_1100, 8'b1100_1001);
            check("small_count", s_blk_count, seq[i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
